// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and the transmitter state encoding.
// Intended to be reused by the matching receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width for a bit period; never narrower than one bit.
  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-valid handshake between the Tx driver (master) and the UART transmitter (slave).
interface uart_tx_if;
  import uart_pkg::*;

  logic                 Tx_dv;
  logic [DATA_BITS-1:0] Tx_Byte;
  logic                 Tx_Active;
  logic                 Tx_Done;

  modport master (
    output Tx_dv,
    output Tx_Byte,
    input  Tx_Active,
    input  Tx_Done
  );

  modport slave (
    input  Tx_dv,
    input  Tx_Byte,
    output Tx_Active,
    output Tx_Done
  );

endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, each held
// CLKS_PER_BIT clocks. All outputs come straight from registers.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  tx_if,
  output logic      Tx_Serial
);

  localparam int                CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int                IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_t            state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [IDX_W-1:0]     idx_q,    idx_d;
  logic [DATA_BITS-1:0] data_q,   data_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q,   done_d;
  logic                 bit_end;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      // NOTE: the byte latch is a datapath register, but it is cleared too so
      // the post-reset state is fully defined.
      data_q   <= '0;
      serial_q <= STOP_BIT;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign bit_end = (cnt_q == CNT_LAST);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        serial_d = STOP_BIT;
        active_d = 1'b0;
        if (tx_if.Tx_dv) begin
          data_d   = tx_if.Tx_Byte;
          cnt_d    = '0;
          idx_d    = '0;
          serial_d = START_BIT;
          active_d = 1'b1;
          state_d  = START;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_d    = '0;
          serial_d = data_q[0];
          state_d  = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            serial_d = STOP_BIT;
            state_d  = STOP;
          end else begin
            idx_d    = idx_q + 1'b1;
            serial_d = data_q[idx_q + 1'b1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_d    = '0;
          active_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign Tx_Serial       = serial_q;
  assign tx_if.Tx_Active = active_q;
  assign tx_if.Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance at CLKS_PER_BIT=4, one at CLKS_PER_BIT=1.
// Inputs change and outputs are sampled on the falling edge.
module tb_uart_tx;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic ser_a, ser_b;
  int   errors = 0;
  int   checks = 0;

  uart_tx_if if_a ();
  uart_tx_if if_b ();

  uart_tx #(.CLKS_PER_BIT(4)) dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .tx_if     (if_a),
    .Tx_Serial (ser_a)
  );

  uart_tx #(.CLKS_PER_BIT(1)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .tx_if     (if_b),
    .Tx_Serial (ser_b)
  );

  // exp holds the frame as {stop, b7..b0, start}; exp[0] is the first bit on the line.
  // mode 0: plain, 1: extra Tx_dv with 0xFF at cycle 10, 2: scramble Tx_Byte every cycle.
  task automatic run_frame(input logic [7:0] b, input logic [9:0] exp, input int mode,
                           input string tag);
    if_a.Tx_dv   = 1'b1;
    if_a.Tx_Byte = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) if_a.Tx_dv = 1'b0;
      if (mode == 1 && k == 10) begin
        if_a.Tx_dv   = 1'b1;
        if_a.Tx_Byte = 8'hFF;
      end
      if (mode == 1 && k == 11) if_a.Tx_dv = 1'b0;
      if (mode == 2) if_a.Tx_Byte = 8'($urandom);
      checks++;
      if (ser_a !== exp[(k-1)/4]) begin
        errors++;
        $display("FAIL %s serial cycle %0d: got %b want %b", tag, k, ser_a, exp[(k-1)/4]);
      end
      checks++;
      if (if_a.Tx_Active !== 1'b1) begin
        errors++;
        $display("FAIL %s active cycle %0d: got %b want 1", tag, k, if_a.Tx_Active);
      end
      checks++;
      if (if_a.Tx_Done !== 1'b0) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %b want 0", tag, k, if_a.Tx_Done);
      end
    end
    @(negedge clk);
    checks++;
    if ({if_a.Tx_Done, if_a.Tx_Active, ser_a} !== 3'b101) begin
      errors++;
      $display("FAIL %s done cycle 41: got done/active/serial %b%b%b want 101", tag,
               if_a.Tx_Done, if_a.Tx_Active, ser_a);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      checks++;
      if ({if_a.Tx_Done, if_a.Tx_Active, ser_a} !== 3'b001) begin
        errors++;
        $display("FAIL %s idle cycle %0d: got done/active/serial %b%b%b want 001", tag, k,
                 if_a.Tx_Done, if_a.Tx_Active, ser_a);
      end
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.Tx_dv   = 1'b1;
    if_a.Tx_Byte = 8'h00;
    if_b.Tx_dv   = 1'b0;
    if_b.Tx_Byte = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_a.Tx_Done, if_a.Tx_Active, ser_a} !== 3'b001) begin
      errors++;
      $display("FAIL reset_a: got done/active/serial %b%b%b want 001",
               if_a.Tx_Done, if_a.Tx_Active, ser_a);
    end
    checks++;
    if ({if_b.Tx_Done, if_b.Tx_Active, ser_b} !== 3'b001) begin
      errors++;
      $display("FAIL reset_b: got done/active/serial %b%b%b want 001",
               if_b.Tx_Done, if_b.Tx_Active, ser_b);
    end
    if_a.Tx_dv = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle_check(3, "reset_release");
  endtask

  task automatic test_single_frame();
    run_frame(8'h55, 10'b1_0101_0101_0, 0, "single_55");
    idle_check(4, "single_after");
  endtask

  task automatic test_back_to_back();
    run_frame(8'hA5, 10'b1_1010_0101_0, 0, "b2b_A5");
    run_frame(8'h3C, 10'b1_0011_1100_0, 0, "b2b_3C");
    idle_check(3, "b2b_after");
  endtask

  task automatic test_busy_reject();
    run_frame(8'h00, 10'b1_0000_0000_0, 1, "busy_00");
    idle_check(45, "busy_no_FF");
  endtask

  task automatic test_byte_stability();
    run_frame(8'hC3, 10'b1_1100_0011_0, 2, "stable_C3");
    idle_check(2, "stable_after");
  endtask

  task automatic test_reset_mid_frame();
    if_a.Tx_dv   = 1'b1;
    if_a.Tx_Byte = 8'h00;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) if_a.Tx_dv = 1'b0;
    end
    checks++;
    if ({if_a.Tx_Active, ser_a} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_bit3: got active/serial %b%b want 10", if_a.Tx_Active, ser_a);
    end
    rst_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_a.Tx_Done, if_a.Tx_Active, ser_a} !== 3'b001) begin
      errors++;
      $display("FAIL midrst_abort: got done/active/serial %b%b%b want 001",
               if_a.Tx_Done, if_a.Tx_Active, ser_a);
    end
    rst_a = 1'b0;
    idle_check(5, "midrst_idle");
    run_frame(8'h81, 10'b1_1000_0001_0, 0, "midrst_81");
    idle_check(2, "midrst_after");
  endtask

  task automatic test_clks1();
    logic [9:0] exp;
    exp = 10'b1_0101_1010_0;
    if_b.Tx_dv   = 1'b1;
    if_b.Tx_Byte = 8'h5A;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) if_b.Tx_dv = 1'b0;
      checks++;
      if ({if_b.Tx_Done, if_b.Tx_Active, ser_b} !== {2'b01, exp[k-1]}) begin
        errors++;
        $display("FAIL cpb1 cycle %0d: got done/active/serial %b%b%b want 01%b", k,
                 if_b.Tx_Done, if_b.Tx_Active, ser_b, exp[k-1]);
      end
    end
    @(negedge clk);
    checks++;
    if ({if_b.Tx_Done, if_b.Tx_Active, ser_b} !== 3'b101) begin
      errors++;
      $display("FAIL cpb1 done cycle 11: got done/active/serial %b%b%b want 101",
               if_b.Tx_Done, if_b.Tx_Active, ser_b);
    end
    @(negedge clk);
    checks++;
    if ({if_b.Tx_Done, if_b.Tx_Active, ser_b} !== 3'b001) begin
      errors++;
      $display("FAIL cpb1 cycle 12: got done/active/serial %b%b%b want 001",
               if_b.Tx_Done, if_b.Tx_Active, ser_b);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_reject();
    test_byte_stability();
    test_reset_mid_frame();
    test_clks1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
